// File: rtl/pc_fetch_if.sv
// pc_fetch handshake bundles: instruction-memory port and decode port.
// The fetch stage is the master of both.
interface pc_fetch_imem_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ack,
    output imem_rdata
  );
endinterface

interface pc_fetch_dec_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );
endinterface

// File: rtl/pc_fetch.sv
// pc_fetch: fetch stage owning the PC, one-entry output register.
// Optional misaligned-redirect trap: define PC_FETCH_MISALIGN_TRAP_EN.
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a + b;
endmodule

module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [31:0]    branch_target,
  pc_fetch_imem_if.master imem,
  pc_fetch_dec_if.master  dec
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  ,
  output logic           fetch_fault
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    ,
    S_FAULT = 2'd2
`endif
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_ifpc;
  logic        r_valid;
  logic [31:0] w_pc_inc;
  logic        w_run;
  logic        w_redir;
  logic        w_misal;
  logic        w_req;
  logic        w_fetch;

  adder u_pc_add (
    .a (r_pc),
    .b (32'd4),
    .y (w_pc_inc)
  );

  assign w_run   = (r_state == S_RUN);
  assign w_redir = w_run & branch_taken;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign w_misal = w_redir & (|branch_target[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  assign w_req = w_run & ~stall & ~branch_taken
               & (~r_valid | dec.if_ready);
  assign w_fetch = w_req & imem.imem_ack;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_RUN;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      S_RUN: if (w_misal) w_state_nxt = S_FAULT;
`else
      S_RUN: w_state_nxt = S_RUN;
`endif
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Redirect beats stall, stall beats fetch/consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_ifpc  <= 32'h0;
    end else if (w_redir) begin
      r_valid <= 1'b0;
      if (!w_misal) r_pc <= branch_target & 32'hFFFF_FFFC;
    end else if (!stall) begin
      if (w_fetch) begin
        r_instr <= imem.imem_rdata;
        r_ifpc  <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= w_pc_inc;
      end else if (r_valid & dec.if_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_fault <= 1'b0;
    else if (w_misal) r_fault <= 1'b1;
  end

  assign fetch_fault = r_fault;
`endif

  assign imem.imem_addr = r_pc;
  assign imem.imem_req  = w_req;
  assign dec.if_valid   = r_valid;
  assign dec.if_instr   = r_instr;
  assign dec.if_pc      = r_ifpc;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage that owns the program counter and feeds the decode stage. Each cycle it may present the current PC to instruction memory over a req/ack handshake, capture the returned word into a one-entry output register, and advance the PC by 4 through the team's 32-bit `adder`. The redirect input loads a branch/jump target in place of the incremented PC. The downstream consumer takes instructions over a valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: freeze the fetch; no new request, and registers hold.
- `branch_taken` input 1: redirect the PC to `branch_target` this cycle.
- `branch_target` input 32: redirect address.
- `imem_addr` output 32: fetch address; always equals the PC register.
- `imem_req` output 1: fetch request.
- `imem_ack` input 1: memory returns `imem_rdata` for `imem_addr` in the same cycle. Ignored when `imem_req`=0.
- `imem_rdata` input 32: instruction word.
- `if_valid` output 1: `if_instr`/`if_pc` hold a valid instruction.
- `if_ready` input 1: decode accepts the instruction this cycle.
- `if_instr` output 32: fetched instruction.
- `if_pc` output 32: address of `if_instr`.
- `fetch_fault` output 1: misaligned-target trap, sticky. Present only with the macro; see Configuration.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN
  - FAULT: only with the macro.
- IDLE → RUN on the first clock edge after `rst_n` deasserts. In IDLE, `imem_req`=0.
- Request condition: `imem_req` = RUN & !`stall` & !`branch_taken` & (!`if_valid` | `if_ready`).
- Fetch (`imem_req` & `imem_ack`), at the edge:
  - `if_instr` ← `imem_rdata`
  - `if_pc` ← PC
  - `if_valid` ← 1
  - PC ← PC + 4, computed by an `adder` instance with b = 32'd4.
- Consume without fetch (`if_valid` & `if_ready` & no fetch): `if_valid` ← 0.
- `imem_req` & !`imem_ack`: PC and `if_*` hold. The request stays asserted next cycle if the request condition still holds.
- Redirect (`branch_taken`=1 in RUN), at the edge:
  - PC ← {`branch_target`[31:2], 2'b00}
  - `if_valid` ← 0; the instruction in the output register is flushed even if `if_ready`=1.
  - No fetch occurs that cycle.
- Priority: `branch_taken` over `stall` over the fetch/consume logic. When `stall`=1 and `branch_taken`=0:
  - PC holds.
  - `if_valid` and `if_*` hold; a consume (`if_valid` & `if_ready`) is ignored.
- Arithmetic: PC + 4 wraps modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000 with no flag.
- `imem_addr`, `if_pc`, and PC bits [1:0] are always 00.

## Timing
- Reset values:
  - PC = `RESET_PC`
  - `imem_req` = 0
  - `if_valid` = 0
  - `if_instr` = 0
  - `if_pc` = 0
  - `fetch_fault` = 0
  - state = IDLE
- Reset asserted mid-operation takes effect immediately (asynchronous). Any in-flight request is abandoned and the captured instruction is lost.
- First `imem_req` is asserted one cycle after reset release.
- Latency: `imem_ack` in cycle N → `if_valid`=1 in cycle N+1.
- Throughput: one instruction per cycle when `imem_ack` and `if_ready` are held high.
- Redirect: `branch_taken` in cycle N → `imem_addr` = target in cycle N+1, and `imem_req` may be asserted in N+1. First redirected instruction is valid in N+2 at the earliest.
- All outputs are registered, except `imem_req`, which is combinational from state, `stall`, `branch_taken`, `if_valid` and `if_ready`.

## Configuration
- `PC_FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `branch_target`[1:0] ≠ 00 sets `fetch_fault` ← 1 and enters FAULT.
  - The PC is not updated and `if_valid` ← 0.
  - In FAULT, `imem_req`=0 permanently, and only reset clears it.
- Macro undefined:
  - No FAULT state and no `fetch_fault` port.
  - Target bits [1:0] are silently forced to 00.

## Test plan
- Reset/startup: release `rst_n` with `RESET_PC`=32'h100, `imem_ack`=1, `if_ready`=1. Expect `imem_req` one cycle later, then `if_pc` = 100, 104, 108 on consecutive cycles, each with `if_valid`=1.
- Backpressure: `if_ready`=0 while `if_valid`=1. Expect `imem_req`=0 and `if_pc`/`if_instr` held. Raising `if_ready` resumes back-to-back fetches with no lost or duplicated PC.
- Stall/ack gaps:
  - `stall`=1 for 3 cycles: PC and outputs hold.
  - `imem_ack`=0 for 2 cycles: the request stays high at the same `imem_addr`.
- Redirect: `branch_taken`=1, `branch_target`=32'h2000 while `if_valid`=1 and `stall`=1. Expect `if_valid`=0 next cycle and `imem_addr`=2000. Next `if_pc`=2000, then 2004.
- Wrap: redirect to 32'hFFFF_FFFC. Expect `if_pc` FFFF_FFFC followed by 0000_0000.
- Misaligned target 32'h2002:
  - With `PC_FETCH_MISALIGN_TRAP_EN`: `fetch_fault`=1, `imem_req` stays 0 until `rst_n` pulses.
  - Without the macro: `if_pc`=2000.
